// File: rtl/decode_stage_riscv_if.sv
// Fetch-to-execute bus of the decode stage: the upstream beat handshake, the
// redirect/interrupt inputs and the decoded control bundle.
interface decode_stage_riscv_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        int_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_pc_o;
    logic [1:0]  ex_op_a_sel_o;
    logic [2:0]  ex_op_b_sel_o;
    logic [4:0]  alu_op_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [2:0]  mem_size_o;
    logic        gpr_we_o;
    logic [1:0]  wb_src_sel_o;
    logic        branch_o;
    logic [1:0]  jump_o;
    logic        csr_o;
    logic        illegal_o;
    logic        int_rst_o;
    logic        trap_o;

    modport slave (
        input  in_valid_i, instr_i, pc_i, int_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, ex_op_a_sel_o, ex_op_b_sel_o,
               alu_op_o, mem_req_o, mem_we_o, mem_size_o, gpr_we_o, wb_src_sel_o,
               branch_o, jump_o, csr_o, illegal_o, int_rst_o, trap_o
    );

    modport master (
        output in_valid_i, instr_i, pc_i, int_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, ex_op_a_sel_o, ex_op_b_sel_o,
               alu_op_o, mem_req_o, mem_we_o, mem_size_o, gpr_we_o, wb_src_sel_o,
               branch_o, jump_o, csr_o, illegal_o, int_rst_o, trap_o
    );
endinterface

// File: rtl/decode_stage_riscv.sv
// RV32I(+M, +Zicsr) decode stage with output register, one-entry skid buffer
// and an interrupt FSM that turns the next accepted beat into a trap beat.
module decode_stage_riscv #(
    parameter int unsigned M_EXT  = 1,
    parameter int unsigned CSR_EN = 1
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    decode_stage_riscv_if.slave  bus
);
    localparam logic [1:0] OPA_RS1   = 2'd0;
    localparam logic [1:0] OPA_PC    = 2'd1;
    localparam logic [1:0] OPA_ZERO  = 2'd2;
    localparam logic [2:0] OPB_RS2   = 3'd0;
    localparam logic [2:0] OPB_IMM_I = 3'd1;
    localparam logic [2:0] OPB_IMM_U = 3'd2;
    localparam logic [2:0] OPB_IMM_S = 3'd3;
    localparam logic [2:0] OPB_INCR  = 3'd4;

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_PEND = 2'd1, ST_WAIT = 2'd2} state_t;

    typedef struct packed {
        logic [1:0] op_a;
        logic [2:0] op_b;
        logic [4:0] alu;
        logic       mem_req;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       gpr_we;
        logic [1:0] wb_src;
        logic       branch;
        logic [1:0] jump;
        logic       csr;
        logic       illegal;
        logic       int_rst;
        logic       trap;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc;
        dec_t        dec;
    } beat_t;

    // ALU codes: {0,alt,funct3} for RV32I, {10,funct3} for MDU, {11,funct3} for branch compares.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic       legal;
        logic [2:0] f3;
        logic [6:0] f7;
        d     = '0;
        legal = 1'b1;
        f3    = ins[14:12];
        f7    = ins[31:25];
        case (ins[6:0])
            7'b0110111: begin d.op_a = OPA_ZERO; d.op_b = OPB_IMM_U; d.gpr_we = 1'b1; end
            7'b0010111: begin d.op_a = OPA_PC;   d.op_b = OPB_IMM_U; d.gpr_we = 1'b1; end
            7'b1101111: begin d.op_a = OPA_PC; d.op_b = OPB_INCR; d.gpr_we = 1'b1; d.jump = 2'b01; end
            7'b1100111: begin
                legal = (f3 == 3'b000);
                d.op_a = OPA_PC; d.op_b = OPB_INCR; d.gpr_we = 1'b1; d.jump = 2'b10;
            end
            7'b1100011: begin
                legal    = (f3 != 3'b010) && (f3 != 3'b011);
                d.op_a   = OPA_RS1; d.op_b = OPB_RS2;
                d.alu    = {2'b11, f3};
                d.branch = 1'b1;
            end
            7'b0000011: begin
                legal = (f3 != 3'd3) && (f3[2:1] != 2'b11);
                d.op_b = OPB_IMM_I; d.mem_req = 1'b1; d.mem_size = f3;
                d.gpr_we = 1'b1; d.wb_src = 2'd1;
            end
            7'b0100011: begin
                legal = (f3[2] == 1'b0) && (f3 != 3'd3);
                d.op_b = OPB_IMM_S; d.mem_req = 1'b1; d.mem_we = 1'b1; d.mem_size = f3;
            end
            7'b0010011: begin
                d.op_b = OPB_IMM_I; d.gpr_we = 1'b1;
                if (f3 == 3'b001) begin
                    legal = (f7 == 7'b0000000);
                    d.alu = {2'b00, f3};
                end else if (f3 == 3'b101) begin
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    d.alu = {1'b0, ins[30], f3};
                end else begin
                    d.alu = {2'b00, f3};
                end
            end
            7'b0110011: begin
                d.op_b = OPB_RS2; d.gpr_we = 1'b1;
                if (f7 == 7'b0000000) begin
                    d.alu = {2'b00, f3};
                end else if (f7 == 7'b0100000) begin
                    legal = (f3 == 3'b000) || (f3 == 3'b101);
                    d.alu = {2'b01, f3};
                end else if (f7 == 7'b0000001) begin
                    legal = (M_EXT != 32'd0);
                    d.alu = {2'b10, f3}; d.wb_src = 2'd3;
                end else begin
                    legal = 1'b0;
                end
            end
            7'b0001111: legal = (f3 == 3'b000);
            7'b1110011: begin
                if (f3 == 3'b000) begin
                    legal = (ins == 32'h3020_0073);
                    d.int_rst = 1'b1;
                end else if (f3 == 3'b100) begin
                    legal = 1'b0;
                end else begin
                    legal = (CSR_EN != 32'd0);
                    d.csr = 1'b1; d.gpr_we = 1'b1; d.wb_src = 2'd2;
                end
            end
            default: legal = 1'b0;
        endcase
        // Illegal beats carry no side effects at all, only the flag.
        if (!legal || (ins[1:0] != 2'b11)) begin
            d         = '0;
            d.illegal = 1'b1;
        end else begin
            d.illegal = 1'b0;
        end
        return d;
    endfunction

    function automatic dec_t trap_dec();
        dec_t d;
        d      = '0;
        d.trap = 1'b1;
        return d;
    endfunction

    state_t state_q, state_d;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
    beat_t  out_data_q, out_data_d, skid_data_q, skid_data_d, new_beat_s;
    logic   accept_s, keep_s, out_free_s;

    assign accept_s       = bus.in_valid_i && in_ready_q && !bus.flush_i;
    assign keep_s         = accept_s && (state_q != ST_WAIT);
    assign out_free_s     = !out_valid_q || bus.out_ready_i;
    assign new_beat_s.pc  = bus.pc_i;
    assign new_beat_s.dec = (state_q == ST_PEND) ? trap_dec() : decode(bus.instr_i);

    // Next-state for the interrupt FSM and the output/skid buffer pair.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        case (state_q)
            ST_RUN:  state_d = bus.int_i ? ST_PEND : ST_RUN;
            ST_PEND: state_d = accept_s ? ST_WAIT : ST_PEND;
            ST_WAIT: state_d = bus.flush_i ? ST_RUN : ST_WAIT;
            default: state_d = ST_RUN;
        endcase
        if (bus.flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free_s) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (keep_s) begin
                out_data_d  = new_beat_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (keep_s) begin
            skid_data_d  = new_beat_s;
            skid_valid_d = 1'b1;
        end else begin
            skid_valid_d = skid_valid_q;
        end
        in_ready_d = (state_d == ST_WAIT) || !skid_valid_d;
    end

    // State, buffer and ready registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= ST_RUN;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready_o    = in_ready_q;
    assign bus.out_valid_o   = out_valid_q;
    assign bus.out_pc_o      = out_data_q.pc;
    assign bus.ex_op_a_sel_o = out_data_q.dec.op_a;
    assign bus.ex_op_b_sel_o = out_data_q.dec.op_b;
    assign bus.alu_op_o      = out_data_q.dec.alu;
    assign bus.mem_req_o     = out_data_q.dec.mem_req;
    assign bus.mem_we_o      = out_data_q.dec.mem_we;
    assign bus.mem_size_o    = out_data_q.dec.mem_size;
    assign bus.gpr_we_o      = out_data_q.dec.gpr_we;
    assign bus.wb_src_sel_o  = out_data_q.dec.wb_src;
    assign bus.branch_o      = out_data_q.dec.branch;
    assign bus.jump_o        = out_data_q.dec.jump;
    assign bus.csr_o         = out_data_q.dec.csr;
    assign bus.illegal_o     = out_data_q.dec.illegal;
    assign bus.int_rst_o     = out_data_q.dec.int_rst;
    assign bus.trap_o        = out_data_q.dec.trap;
endmodule

// File: tb/tb_decode_stage_riscv.sv
// Directed bench for decode_stage_riscv: a full-featured and a base-ISA-only
// instance share one stimulus and are checked against a beat-queue model.
module tb_decode_stage_riscv;
    typedef struct packed {
        logic [1:0] op_a;
        logic [2:0] op_b;
        logic [4:0] alu;
        logic       mem_req;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       gpr_we;
        logic [1:0] wb;
        logic       branch;
        logic [1:0] jump;
        logic       csr;
        logic       illegal;
        logic       int_rst;
        logic       trap;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bit          trap;
    } mbeat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, int_i, flush, out_ready;
    logic [31:0] instr, pc;
    int          checks = 0;
    int          failures = 0;

    mbeat_t mq[$];
    bit     pending = 1'b0;
    bit     discarding = 1'b0;
    bit     m_ready = 1'b1;

    decode_stage_riscv_if ifa ();
    decode_stage_riscv_if ifb ();

    assign ifa.in_valid_i = in_valid;  assign ifb.in_valid_i = in_valid;
    assign ifa.instr_i = instr;        assign ifb.instr_i = instr;
    assign ifa.pc_i = pc;              assign ifb.pc_i = pc;
    assign ifa.int_i = int_i;          assign ifb.int_i = int_i;
    assign ifa.flush_i = flush;        assign ifb.flush_i = flush;
    assign ifa.out_ready_i = out_ready; assign ifb.out_ready_i = out_ready;

    decode_stage_riscv u_dut_a (.clk_i(clk), .arst_n_i(rst_n), .bus(ifa));
    decode_stage_riscv #(.M_EXT(0), .CSR_EN(0)) u_dut_b (.clk_i(clk), .arst_n_i(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    logic [24:0] obs_a, obs_b;
    assign obs_a = {ifa.ex_op_a_sel_o, ifa.ex_op_b_sel_o, ifa.alu_op_o, ifa.mem_req_o, ifa.mem_we_o,
                    ifa.mem_size_o, ifa.gpr_we_o, ifa.wb_src_sel_o, ifa.branch_o, ifa.jump_o,
                    ifa.csr_o, ifa.illegal_o, ifa.int_rst_o, ifa.trap_o};
    assign obs_b = {ifb.ex_op_a_sel_o, ifb.ex_op_b_sel_o, ifb.alu_op_o, ifb.mem_req_o, ifb.mem_we_o,
                    ifb.mem_size_o, ifb.gpr_we_o, ifb.wb_src_sel_o, ifb.branch_o, ifb.jump_o,
                    ifb.csr_o, ifb.illegal_o, ifb.int_rst_o, ifb.trap_o};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Instruction-set rules; op_a 0 RS1/1 PC/2 ZERO, op_b 0 RS2/1 I/2 U/3 S/4 INCR.
    function automatic exp_t model_dec(input logic [31:0] ins, input bit m, input bit c);
        exp_t       e;
        bit         ok;
        logic [2:0] f3;
        logic [6:0] f7;
        e = '0; ok = 1'b0; f3 = ins[14:12]; f7 = ins[31:25];
        case (ins[6:0])
            7'h37: begin ok = 1'b1; e.op_a = 2'd2; e.op_b = 3'd2; e.gpr_we = 1'b1; end
            7'h17: begin ok = 1'b1; e.op_a = 2'd1; e.op_b = 3'd2; e.gpr_we = 1'b1; end
            7'h6F: begin ok = 1'b1; e.op_a = 2'd1; e.op_b = 3'd4; e.gpr_we = 1'b1; e.jump = 2'b01; end
            7'h67: begin ok = (f3 == 3'd0); e.op_a = 2'd1; e.op_b = 3'd4; e.gpr_we = 1'b1; e.jump = 2'b10; end
            7'h63: begin ok = !(f3 == 3'd2 || f3 == 3'd3); e.alu = {2'b11, f3}; e.branch = 1'b1; end
            7'h03: begin
                ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
                e.op_b = 3'd1; e.mem_req = 1'b1; e.mem_size = f3; e.gpr_we = 1'b1; e.wb = 2'd1;
            end
            7'h23: begin ok = (f3 <= 3'd2); e.op_b = 3'd3; e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_size = f3; end
            7'h13: begin
                e.op_b = 3'd1; e.gpr_we = 1'b1;
                e.alu = {1'b0, (f3 == 3'd5) ? ins[30] : 1'b0, f3};
                ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            end
            7'h33: begin
                e.gpr_we = 1'b1;
                if (f7 == 7'h01) begin ok = m; e.alu = {2'b10, f3}; e.wb = 2'd3; end
                else begin ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)); e.alu = {1'b0, f7[5], f3}; end
            end
            7'h0F: ok = (f3 == 3'd0);
            7'h73: begin
                if (ins == 32'h3020_0073) begin ok = 1'b1; e.int_rst = 1'b1; end
                else if (f3 != 3'd0 && f3 != 3'd4) begin ok = c; e.csr = 1'b1; e.gpr_we = 1'b1; e.wb = 2'd2; end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin e = '0; e.illegal = 1'b1; end
        return e;
    endfunction

    function automatic exp_t expect_of(input mbeat_t b, input bit m, input bit c);
        exp_t e;
        if (b.trap) begin e = '0; e.trap = 1'b1; end
        else e = model_dec(b.instr, m, c);
        return e;
    endfunction

    // Beat-level model: up to two beats held, interrupt arms a trap, then discard until flush.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete(); pending = 1'b0; discarding = 1'b0; m_ready = 1'b1;
            end else begin
                automatic bit acc = in_valid && m_ready && !flush;
                if (flush) mq.delete();
                else begin
                    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                    if (acc && !discarding) mq.push_back('{instr, pc, pending});
                end
                if (discarding) begin
                    if (flush) discarding = 1'b0;
                end else if (pending) begin
                    if (acc) begin pending = 1'b0; discarding = 1'b1; end
                end else if (int_i) begin
                    pending = 1'b1;
                end
                m_ready = discarding || (mq.size() < 2);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("a_in_ready", 32'(ifa.in_ready_o), 32'(m_ready));
            chk("b_in_ready", 32'(ifb.in_ready_o), 32'(m_ready));
            chk("a_out_valid", 32'(ifa.out_valid_o), 32'(mq.size() > 0));
            chk("b_out_valid", 32'(ifb.out_valid_o), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("a_out_pc", ifa.out_pc_o, mq[0].pc);
                chk("b_out_pc", ifb.out_pc_o, mq[0].pc);
                chk("a_fields", 32'(obs_a), 32'(expect_of(mq[0], 1'b1, 1'b1)));
                chk("b_fields", 32'(obs_b), 32'(expect_of(mq[0], 1'b0, 1'b0)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
        in_valid = v; instr = ins; pc = p;
    endtask

    logic [31:0] tbl [0:27] = '{
        32'h123450B7, 32'h00001117, 32'h000000EF, 32'h000100E7, 32'h000110E7, 32'h00208063,
        32'h0020A063, 32'h0000A183, 32'h0000B183, 32'h0020A023, 32'h0020B023, 32'h00309093,
        32'h40309093, 32'h4030D093, 32'h002080B3, 32'h402080B3, 32'h4020D0B3, 32'h4020A0B3,
        32'h0220C033, 32'h300110F3, 32'h300160F3, 32'h300140F3, 32'h30200073, 32'h00000073,
        32'h00100073, 32'h0FF0000F, 32'h00004501, 32'h0000C183};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; pc = 32'd0;
        int_i = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", 32'(ifa.out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(ifa.in_ready_o), 32'd1);
        rst_n = 1'b1; out_ready = 1'b1; step();

        drive(1'b1, 32'h00500093, 32'h100); step(); drive(1'b0, 32'd0, 32'd0);
        chk("addi_valid", 32'(ifa.out_valid_o), 32'd1);
        chk("addi_alu", 32'(ifa.alu_op_o), 32'd0);
        chk("addi_opb", 32'(ifa.ex_op_b_sel_o), 32'd1);
        chk("addi_gpr", 32'(ifa.gpr_we_o), 32'd1);
        chk("addi_pc", ifa.out_pc_o, 32'h100);

        drive(1'b1, 32'h02208033, 32'h104); step(); drive(1'b0, 32'd0, 32'd0);
        chk("mul_a_wb", 32'(ifa.wb_src_sel_o), 32'd3);
        chk("mul_a_alu", 32'(ifa.alu_op_o), 32'h10);
        chk("mul_b_illegal", 32'(ifb.illegal_o), 32'd1);
        chk("mul_b_gpr", 32'(ifb.gpr_we_o), 32'd0);

        for (int i = 0; i < 28; i++) begin
            drive(1'b1, tbl[i], 32'h1000 + 32'(i * 4)); step();
        end
        drive(1'b0, 32'd0, 32'd0); step(); step();

        out_ready = 1'b0;
        drive(1'b1, 32'h002080B3, 32'h300); step();
        chk("bp_ready_first", 32'(ifa.in_ready_o), 32'd1);
        drive(1'b1, 32'h0000A183, 32'h304); step();
        chk("bp_ready_low", 32'(ifa.in_ready_o), 32'd0);
        drive(1'b1, 32'h0020A023, 32'h308);
        repeat (3) begin
            step();
            chk("bp_hold_pc", ifa.out_pc_o, 32'h300);
            chk("bp_hold_alu", 32'(ifa.alu_op_o), 32'd0);
        end
        out_ready = 1'b1; step();
        chk("bp_second_pc", ifa.out_pc_o, 32'h304);
        step();
        chk("bp_third_pc", ifa.out_pc_o, 32'h308);
        drive(1'b0, 32'd0, 32'd0); step();
        chk("bp_drained", 32'(ifa.out_valid_o), 32'd0);

        int_i = 1'b1; drive(1'b1, 32'h00500093, 32'h400); step(); int_i = 1'b0;
        chk("irq_same_cycle_trap", 32'(ifa.trap_o), 32'd0);
        chk("irq_same_cycle_gpr", 32'(ifa.gpr_we_o), 32'd1);
        drive(1'b1, 32'h0000A183, 32'h404); step();
        chk("trap_flag", 32'(ifa.trap_o), 32'd1);
        chk("trap_mem_req", 32'(ifa.mem_req_o), 32'd0);
        chk("trap_pc", ifa.out_pc_o, 32'h404);
        drive(1'b1, 32'h00500093, 32'h408); step(); step();
        chk("wait_dropped", 32'(ifa.out_valid_o), 32'd0);
        chk("wait_ready", 32'(ifa.in_ready_o), 32'd1);
        drive(1'b0, 32'd0, 32'd0); flush = 1'b1; step(); flush = 1'b0;
        drive(1'b1, 32'h00500093, 32'h40C); step(); drive(1'b0, 32'd0, 32'd0);
        chk("resume_trap", 32'(ifa.trap_o), 32'd0);
        chk("resume_pc", ifa.out_pc_o, 32'h40C);

        out_ready = 1'b0;
        drive(1'b1, 32'h002080B3, 32'h500); step();
        drive(1'b1, 32'h0000A183, 32'h504); step();
        flush = 1'b1; drive(1'b1, 32'h0020A023, 32'h508); step();
        flush = 1'b0; drive(1'b0, 32'd0, 32'd0);
        chk("flush_valid", 32'(ifa.out_valid_o), 32'd0);
        chk("flush_ready", 32'(ifa.in_ready_o), 32'd1);
        out_ready = 1'b1; step(); step();
        chk("flush_no_stale", 32'(ifa.out_valid_o), 32'd0);

        int_i = 1'b1; step(); int_i = 1'b0;
        flush = 1'b1; drive(1'b1, 32'h002080B3, 32'h600); step(); flush = 1'b0;
        drive(1'b1, 32'h0000A183, 32'h604); step(); drive(1'b0, 32'd0, 32'd0);
        chk("pend_flush_trap", 32'(ifa.trap_o), 32'd1);
        chk("pend_flush_pc", ifa.out_pc_o, 32'h604);
        flush = 1'b1; step(); flush = 1'b0; step();

        out_ready = 1'b0;
        drive(1'b1, 32'h002080B3, 32'h700); step();
        drive(1'b1, 32'h0000A183, 32'h704); step(); drive(1'b0, 32'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ifa.out_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(ifa.in_ready_o), 32'd1);
        step(); rst_n = 1'b1; out_ready = 1'b1; step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage_riscv.md
DECODE_STAGE_RISCV -- requirements
Module: decode_stage_riscv

Interface
REQ-001 The block SHALL have parameter M_EXT, default 1, which enables decode of RV32M (OP, funct7=0000001).
REQ-002 The block SHALL have parameter CSR_EN, default 1, which enables decode of Zicsr (SYSTEM, funct3 in {1,2,3,5,6,7}).
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port arst_n_i, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port in_valid_i, input, 1, fetch beat valid.
REQ-006 The block SHALL have port in_ready_o, output, 1, stage accepts a beat.
REQ-007 The block SHALL have port instr_i, input, 32, fetched instruction.
REQ-008 The block SHALL have port pc_i, input, 32, PC of instr_i.
REQ-009 The block SHALL have port int_i, input, 1, interrupt request level.
REQ-010 The block SHALL have port flush_i, input, 1, frontend redirect.
REQ-011 The block SHALL have port out_valid_o, output, 1, decoded beat valid.
REQ-012 The block SHALL have port out_ready_i, input, 1, execute accepts the beat.
REQ-013 The block SHALL have port out_pc_o, output, 32, PC of the decoded beat.
REQ-014 The block SHALL have port ex_op_a_sel_o, output, 2, operand A select: RS1, CURR_PC or ZERO.
REQ-015 The block SHALL have port ex_op_b_sel_o, output, 3, operand B select: RS2, IMM_I, IMM_U, IMM_S or INCR.
REQ-016 The block SHALL have port alu_op_o, output, 5, ALU operation code.
REQ-017 The block SHALL have port mem_req_o, output, 1, LSU request.
REQ-018 The block SHALL have port mem_we_o, output, 1, LSU write.
REQ-019 The block SHALL have port mem_size_o, output, 3, LSU size (funct3).
REQ-020 The block SHALL have port gpr_we_o, output, 1, register-file write.
REQ-021 The block SHALL have port wb_src_sel_o, output, 2, writeback source: 0 EX, 1 LSU, 2 CSR, 3 MDU.
REQ-022 The block SHALL have port branch_o, output, 1, conditional branch.
REQ-023 The block SHALL have port jump_o, output, 2, jump type: 01 JAL, 10 JALR.
REQ-024 The block SHALL have port csr_o, output, 1, CSR access.
REQ-025 The block SHALL have port illegal_o, output, 1, illegal instruction.
REQ-026 The block SHALL have port int_rst_o, output, 1, MRET decoded.
REQ-027 The block SHALL have port trap_o, output, 1, interrupt-trap beat.

Function
REQ-028 Buffering SHALL be an output register plus a one-entry skid register; in_ready_o=!skid_valid; accepted-to-out_valid latency one cycle; no beat is lost or duplicated.
REQ-029 A beat SHALL transfer out when out_valid_o&&out_ready_i; while out_ready_i=0 the outputs SHALL hold stable; skid contents SHALL drain before any new input.
REQ-030 Decode SHALL be RV32I: LOAD funct3 in {0,1,2,4,5}; STORE in {0,1,2}; BRANCH funct3 010/011 illegal; JALR funct3!=0 illegal; shifts SHALL check funct7 (SRA=0100000); OP funct7 0100000 SHALL be legal only for funct3 000/101; instr[1:0]!=11 SHALL be illegal.
REQ-031 With M_EXT=1, OP funct7=0000001 SHALL give wb_src_sel_o=3, gpr_we_o=1 and alu_op_o={2'b10,funct3}; with M_EXT=0 it SHALL be illegal.
REQ-032 With CSR_EN=1, CSR funct3 (not 0, not 4) SHALL give csr_o=1, gpr_we_o=1 and wb_src_sel_o=2; with CSR_EN=0 it SHALL be illegal.
REQ-033 0x30200073 SHALL give int_rst_o=1; ECALL, EBREAK and other SYSTEM funct3=0 encodings SHALL be illegal.
REQ-034 Whenever illegal_o=1 or trap_o=1, mem_req_o, mem_we_o, gpr_we_o, branch_o, jump_o, csr_o and int_rst_o SHALL all be 0.
REQ-035 The FSM SHALL have states RUN, PEND and WAIT; RUN SHALL go to PEND when int_i=1.
REQ-036 In PEND, the next accepted beat SHALL be emitted with trap_o=1 and its own PC and all side-effect outputs 0, then the FSM SHALL go to WAIT.
REQ-037 In WAIT, in_ready_o SHALL be 1 and input beats SHALL be discarded; flush_i SHALL move WAIT to RUN.
REQ-038 flush_i SHALL clear the output and skid valids next cycle, and a beat offered in the same cycle SHALL be dropped; PEND SHALL survive flush_i.
REQ-039 If int_i rises in the same cycle as an accept in RUN, that beat SHALL decode normally and the following accepted beat SHALL become the trap.

Reset
REQ-040 Reset SHALL put the FSM in RUN, clear both valids and set every registered output to 0, so out_valid_o=0 and in_ready_o=1; mid-operation reset SHALL discard held beats immediately.

Verification
REQ-041 Directed: ADDI x1,x0,5 (0x00500093) at pc 0x100 -> next cycle out_valid_o=1, alu_op_o=ADD, ex_op_b_sel_o=IMM_I, gpr_we_o=1, out_pc_o=0x100.
REQ-042 Directed: out_ready_i=0 for 3 cycles while 2 beats are offered -> in_ready_o falls after the second, outputs stable; on release both emerge in order.
REQ-043 Directed: MUL 0x02208033 with M_EXT=0 -> illegal_o=1, gpr_we_o=0; with M_EXT=1 -> wb_src_sel_o=3.
REQ-044 Directed: int_i pulse, then LW -> trap_o=1, mem_req_o=0; following beats dropped until flush_i, then normal decode resumes.
REQ-045 Directed: flush_i together with in_valid_i and a full skid -> out_valid_o=0 next cycle, no stale beat emitted.
